// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction loader and the core's
// main/ALU decoders: request kind codes, opcodes, funct3/funct7 values and
// the loader FSM state type.
package rv_isa_pkg;

  // Request kind codes; 9..15 are illegal.
  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_XOR  = 4'd4,
    K_ADDI = 4'd5,
    K_LW   = 4'd6,
    K_SW   = 4'd7,
    K_BEQ  = 4'd8
  } kind_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } ld_state_e;

endpackage

// File: rtl/rv_instr_enc.sv
// Combinational RV32I encoder: packs a symbolic request into a 32-bit word.
// Ports:
//   kind_i   request kind code (see rv_isa_pkg::kind_e)
//   rd_i, rs1_i, rs2_i  register indices
//   imm_i    13-bit signed immediate (I/S use [11:0], BEQ uses [12:1])
//   word_o   encoded instruction; fields unused by the kind are zero
//   legal_o  high when kind_i is a supported kind
module rv_instr_enc
  import rv_isa_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (kind_e'(kind_i))
      K_ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_R};
      K_SUB:  word_o = {F7_SUB,  rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_R};
      K_AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i, OP_R};
      K_OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i, OP_R};
      K_XOR:  word_o = {F7_BASE, rs2_i, rs1_i, F3_XOR,     rd_i, OP_R};
      K_ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OP_IMM};
      K_LW:   word_o = {imm_i[11:0], rs1_i, F3_LW,   rd_i, OP_LOAD};
      K_SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_STORE};
      // B-type scatters the halfword offset; imm_i[0] is dropped.
      K_BEQ:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                        imm_i[4:1], imm_i[11], OP_BRANCH};
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_instr_loader.sv
// Sequential instruction loader: accepts symbolic requests over valid/ready,
// encodes them and writes consecutive instruction-memory words from address 0.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, finish     enter LOAD (clearing pointer/err) / return to IDLE
//   req_*             request handshake and fields
//   imem_we/addr/wdata registered one-cycle write to instruction memory
//   wcount            legal requests accepted since start
//   busy              FSM in LOAD
//   err               sticky: an illegal kind was accepted
module rv_instr_loader
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [12:0]   req_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   wcount,
  output logic          busy,
  output logic          err
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  ld_state_e     state_q, state_d;
  logic [AW:0]   wcount_q, wcount_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;

  rv_instr_enc u_enc (
    .kind_i  (req_kind),
    .rd_i    (req_rd),
    .rs1_i   (req_rs1),
    .rs2_i   (req_rs2),
    .imm_i   (req_imm),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  // Ready depends only on registered state, never on req_valid.
  assign req_ready = (state_q == S_LOAD) && (wcount_q < DEPTH_CNT);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    wcount_d = wcount_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          wcount_d = '0;
          err_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (finish)                     state_d = S_IDLE;
        else if (wcount_q == DEPTH_CNT) state_d = S_FULL;
      end
      S_FULL: begin
        // start takes priority over a simultaneous finish.
        if (start) begin
          state_d  = S_LOAD;
          wcount_d = '0;
          err_d    = 1'b0;
        end else if (finish) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance only happens in LOAD, so it never collides with a start clear.
    if (accept) begin
      if (enc_legal) begin
        we_d     = 1'b1;
        addr_d   = wcount_q[AW-1:0];
        wdata_d  = enc_word;
        wcount_d = wcount_q + (AW+1)'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wcount_q <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcount_q <= wcount_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign wcount     = wcount_q;
  assign busy       = (state_q == S_LOAD);
  assign err        = err_q;

endmodule

// File: tb/tb_rv_instr_loader.sv
module tb_rv_instr_loader;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, finish, req_valid;
  logic [3:0]  req_kind;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [12:0] req_imm;

  // DEPTH = 64 instance
  logic        rdy64, we64, busy64, err64;
  logic [5:0]  addr64;
  logic [31:0] wdata64;
  logic [6:0]  wcount64;

  // DEPTH = 4 instance (same stimulus)
  logic        rdy4, we4, busy4, err4;
  logic [1:0]  addr4;
  logic [31:0] wdata4;
  logic [2:0]  wcount4;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  rv_instr_loader #(.DEPTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(rdy64), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(we64), .imem_addr(addr64), .imem_wdata(wdata64),
    .wcount(wcount64), .busy(busy64), .err(err64)
  );

  rv_instr_loader #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(rdy4), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
    .wcount(wcount4), .busy(busy4), .err(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] k, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [12:0] imm);
    req_valid = v; req_kind = k; req_rd = rd; req_rs1 = r1; req_rs2 = r2; req_imm = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; finish = 1'b0;
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step(); step();
    n_total++; if (we64 !== 1'b0)      $display("FAIL rst_we got %b exp 0", we64); else n_pass++;
    n_total++; if (addr64 !== 6'd0)    $display("FAIL rst_addr got %h exp 0", addr64); else n_pass++;
    n_total++; if (wdata64 !== 32'd0)  $display("FAIL rst_wdata got %h exp 0", wdata64); else n_pass++;
    n_total++; if (wcount64 !== 7'd0)  $display("FAIL rst_wcount got %0d exp 0", wcount64); else n_pass++;
    n_total++; if (busy64 !== 1'b0)    $display("FAIL rst_busy got %b exp 0", busy64); else n_pass++;
    n_total++; if (err64 !== 1'b0)     $display("FAIL rst_err got %b exp 0", err64); else n_pass++;
    n_total++; if (rdy64 !== 1'b0)     $display("FAIL rst_ready got %b exp 0", rdy64); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (busy64 !== 1'b1) $display("FAIL start_busy got %b exp 1", busy64); else n_pass++;
    n_total++; if (rdy64 !== 1'b1)  $display("FAIL start_ready got %b exp 1", rdy64); else n_pass++;
    n_total++; if (we64 !== 1'b0)   $display("FAIL start_we got %b exp 0", we64); else n_pass++;
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    step();
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    n_total++; if (we64 !== 1'b1)            $display("FAIL add_we got %b exp 1", we64); else n_pass++;
    n_total++; if (addr64 !== 6'd0)          $display("FAIL add_addr got %0d exp 0", addr64); else n_pass++;
    n_total++; if (wdata64 !== 32'h002081B3) $display("FAIL add_wdata got %h exp 002081b3", wdata64); else n_pass++;
    n_total++; if (wcount64 !== 7'd1)        $display("FAIL add_wcount got %0d exp 1", wcount64); else n_pass++;
    step();
    n_total++; if (we64 !== 1'b0) $display("FAIL add_we_drop got %b exp 0", we64); else n_pass++;
  endtask

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  task automatic test_back_to_back();
    vec_t tbl[10];
    tbl[0] = '{4'd1, 5'd5,  5'd6, 5'd7,  13'h0000, 32'h407302B3}; // SUB
    tbl[1] = '{4'd6, 5'd4,  5'd2, 5'd0,  13'h0008, 32'h00812203}; // LW x4,8(x2)
    tbl[2] = '{4'd7, 5'd0,  5'd2, 5'd5,  13'h000C, 32'h00512623}; // SW x5,12(x2)
    tbl[3] = '{4'd8, 5'd0,  5'd1, 5'd2,  13'h1FFC, 32'hFE208EE3}; // BEQ -4
    tbl[4] = '{4'd5, 5'd1,  5'd0, 5'd0,  13'h0FFF, 32'hFFF00093}; // ADDI x1,x0,-1
    tbl[5] = '{4'd2, 5'd1,  5'd2, 5'd3,  13'h0000, 32'h003170B3}; // AND
    tbl[6] = '{4'd3, 5'd1,  5'd2, 5'd3,  13'h0000, 32'h003160B3}; // OR
    tbl[7] = '{4'd4, 5'd1,  5'd2, 5'd3,  13'h0000, 32'h003140B3}; // XOR
    tbl[8] = '{4'd6, 5'd4,  5'd2, 5'd31, 13'h1800, 32'h80012203}; // LW, rs2/imm[12] ignored
    tbl[9] = '{4'd8, 5'd31, 5'd0, 5'd0,  13'h0011, 32'h00000863}; // BEQ, rd/imm[0] ignored
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, tbl[i].kind, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      step();
      n_total++; if (we64 !== 1'b1) $display("FAIL b2b_we[%0d] got %b exp 1", i, we64); else n_pass++;
      n_total++; if (addr64 !== 6'(i + 1)) $display("FAIL b2b_addr[%0d] got %0d exp %0d", i, addr64, i + 1); else n_pass++;
      n_total++; if (wdata64 !== tbl[i].exp) $display("FAIL b2b_wdata[%0d] got %h exp %h", i, wdata64, tbl[i].exp); else n_pass++;
    end
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    n_total++; if (we64 !== 1'b0)      $display("FAIL b2b_end_we got %b exp 0", we64); else n_pass++;
    n_total++; if (wcount64 !== 7'd11) $display("FAIL b2b_wcount got %0d exp 11", wcount64); else n_pass++;
  endtask

  task automatic test_illegal();
    set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    n_total++; if (we64 !== 1'b1 || addr64 !== 6'd11 || wdata64 !== 32'h003100B3)
      $display("FAIL ill_pre got we=%b addr=%0d data=%h exp 1/11/003100b3", we64, addr64, wdata64); else n_pass++;
    set_req(1'b1, 4'd12, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    n_total++; if (we64 !== 1'b0)      $display("FAIL ill_we got %b exp 0", we64); else n_pass++;
    n_total++; if (err64 !== 1'b1)     $display("FAIL ill_err got %b exp 1", err64); else n_pass++;
    n_total++; if (wcount64 !== 7'd12) $display("FAIL ill_wcount got %0d exp 12", wcount64); else n_pass++;
    set_req(1'b1, 4'd0, 5'd4, 5'd4, 5'd4, 13'd0);
    step();
    n_total++; if (we64 !== 1'b1 || addr64 !== 6'd12 || wdata64 !== 32'h00420233)
      $display("FAIL ill_post got we=%b addr=%0d data=%h exp 1/12/00420233", we64, addr64, wdata64); else n_pass++;
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    step();
    n_total++; if (err64 !== 1'b1)     $display("FAIL ill_sticky got %b exp 1", err64); else n_pass++;
    n_total++; if (wcount64 !== 7'd13) $display("FAIL ill_wcount2 got %0d exp 13", wcount64); else n_pass++;
  endtask

  task automatic test_start_finish();
    start = 1'b1;
    set_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    start = 1'b0;
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    n_total++; if (busy64 !== 1'b1)    $display("FAIL sil_busy got %b exp 1", busy64); else n_pass++;
    n_total++; if (wcount64 !== 7'd14) $display("FAIL sil_wcount got %0d exp 14", wcount64); else n_pass++;
    n_total++; if (err64 !== 1'b1)     $display("FAIL sil_err got %b exp 1", err64); else n_pass++;
    n_total++; if (we64 !== 1'b1 || addr64 !== 6'd13)
      $display("FAIL sil_write got we=%b addr=%0d exp 1/13", we64, addr64); else n_pass++;
    finish = 1'b1;
    step();
    finish = 1'b0;
    n_total++; if (busy64 !== 1'b0) $display("FAIL fin_busy got %b exp 0", busy64); else n_pass++;
    n_total++; if (rdy64 !== 1'b0)  $display("FAIL fin_ready got %b exp 0", rdy64); else n_pass++;
    start = 1'b1; finish = 1'b1;
    step();
    start = 1'b0; finish = 1'b0;
    n_total++; if (busy64 !== 1'b1)   $display("FAIL sf_busy got %b exp 1", busy64); else n_pass++;
    n_total++; if (wcount64 !== 7'd0) $display("FAIL sf_wcount got %0d exp 0", wcount64); else n_pass++;
    n_total++; if (err64 !== 1'b0)    $display("FAIL sf_err got %b exp 0", err64); else n_pass++;
  endtask

  task automatic test_fill_depth4();
    int unsigned nwr = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    for (int j = 0; j < 6; j++) begin
      step();
      if (we4 === 1'b1) nwr++;
      if (j < 4) begin
        n_total++; if (we4 !== 1'b1 || addr4 !== 2'(j) || wdata4 !== 32'h002081B3)
          $display("FAIL fill_wr[%0d] got we=%b addr=%0d data=%h exp 1/%0d/002081b3", j, we4, addr4, wdata4, j);
        else n_pass++;
      end else begin
        n_total++; if (we4 !== 1'b0) $display("FAIL fill_nowr[%0d] got %b exp 0", j, we4); else n_pass++;
      end
      if (j == 3) begin
        n_total++; if (rdy4 !== 1'b0) $display("FAIL fill_ready got %b exp 0", rdy4); else n_pass++;
      end
    end
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    n_total++; if (nwr != 4)                $display("FAIL fill_count got %0d exp 4", nwr); else n_pass++;
    n_total++; if (wcount4 !== 3'd4)        $display("FAIL fill_wcount got %0d exp 4", wcount4); else n_pass++;
    n_total++; if (u_dut4.state_q !== S_FULL) $display("FAIL fill_state got %0d exp %0d", u_dut4.state_q, S_FULL); else n_pass++;
    n_total++; if (busy4 !== 1'b0)          $display("FAIL fill_busy got %b exp 0", busy4); else n_pass++;
    n_total++; if (addr4 !== 2'd3)          $display("FAIL fill_addr_hold got %0d exp 3", addr4); else n_pass++;
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++; if (wcount4 !== 3'd0 || busy4 !== 1'b1 || rdy4 !== 1'b1)
      $display("FAIL fill_restart got wcount=%0d busy=%b ready=%b exp 0/1/1", wcount4, busy4, rdy4); else n_pass++;
  endtask

  task automatic test_reset_pending();
    // u_dut is in LOAD here; accept one request then reset right after.
    set_req(1'b1, 4'd4, 5'd1, 5'd2, 5'd3, 13'd0);
    step();
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    rst_n = 1'b0;
    #1;
    n_total++; if (we64 !== 1'b0 || addr64 !== 6'd0 || wdata64 !== 32'd0)
      $display("FAIL rp_out got we=%b addr=%0d data=%h exp 0/0/0", we64, addr64, wdata64); else n_pass++;
    n_total++; if (wcount64 !== 7'd0 || busy64 !== 1'b0 || err64 !== 1'b0)
      $display("FAIL rp_ctl got wcount=%0d busy=%b err=%b exp 0/0/0", wcount64, busy64, err64); else n_pass++;
    n_total++; if (u_dut.state_q !== S_IDLE) $display("FAIL rp_state got %0d exp %0d", u_dut.state_q, S_IDLE); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_total++; if (we64 !== 1'b0 || busy64 !== 1'b0)
      $display("FAIL rp_after got we=%b busy=%b exp 0/0", we64, busy64); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_start_finish();
    test_fill_depth4();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_instr_loader.md
# rv_instr_loader

- Sequential instruction encoder and loader: the encode-side counterpart of the core's decode path.
- Accepts symbolic operation requests (kind, rd, rs1, rs2, imm) over a valid/ready handshake and packs each into a 32-bit RV32I word, so `rv_instr_enc` produces exactly the fields the main decoder and ALU decoder consume.
- Writes the words to consecutive instruction-memory addresses from 0.
- Sits between the testbench/boot host and instruction memory; it is used to build programs without hand-encoded hex.

## Interface

Parameters:

- DEPTH, 64, instruction-memory size in words; loading stops at DEPTH
- AW, $clog2(DEPTH), word-address width

Ports:

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: clear pointer and error, enter LOAD; honored only in IDLE or FULL
- finish  in  1  pulse: leave LOAD for IDLE
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDI, 6 LW, 7 SW, 8 BEQ; 9–15 illegal
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  13  signed immediate; I/S kinds use [11:0]; BEQ uses [12:1] and ignores [0]
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- wcount  out  AW+1  legal requests accepted since start
- busy  out  1  state == LOAD
- err  out  1  sticky; an illegal kind was accepted

## Operation

- States and transitions:
  - IDLE (reset state): start → LOAD.
  - LOAD: finish → IDLE; wcount == DEPTH → FULL.
  - FULL: start → LOAD; finish → IDLE.
  - start is ignored in LOAD.
  - finish and start in the same cycle in IDLE or FULL: start wins.
- req_ready = (state == LOAD) && (wcount < DEPTH). It is purely state-derived and does not depend on req_valid.
- Accepted legal request:
  - Encode the fields.
  - Register imem_wdata and imem_addr = wcount[AW-1:0].
  - Assert imem_we next cycle.
  - wcount increments at the acceptance edge.
- Accepted illegal kind: consumed, no write, wcount unchanged, err set to 1. err clears only on start or reset.
- Encoding rules:
  - R-type: opcode 0110011; funct7 = 0100000 for SUB, otherwise 0000000; funct3 = ADD/SUB 000, AND 111, OR 110, XOR 100.
  - ADDI: opcode 0010011, funct3 000, [31:20] = imm[11:0].
  - LW: opcode 0000011, funct3 010, [31:20] = imm[11:0].
  - SW: opcode 0100011, funct3 010, [31:25] = imm[11:5], [11:7] = imm[4:0].
  - BEQ: opcode 1100011, funct3 000, [31] = imm[12], [30:25] = imm[10:5], [11:8] = imm[4:1], [7] = imm[11].
  - Fields a kind does not use are zero. Examples: rs2 for I-type, rd for S/B-type.
- On finish, a write already registered still completes in the following cycle.
- Asynchronous reset: state IDLE; wcount, err, imem_we, imem_addr, imem_wdata all 0. A write pending at reset is dropped.

## Timing

- Latency: acceptance at edge k → imem_we high during cycle k+1, with address and data stable in that cycle.
- Throughput: one word per cycle while req_valid is held.
- FULL boundary:
  - The DEPTH-th acceptance raises wcount to DEPTH, and req_ready is low from the next cycle.
  - Its write still appears one cycle later, at address DEPTH-1.
  - The address never wraps.
- busy and req_ready are registered-state outputs: no combinational path from req_valid, start or finish.

## Structure

- Package rv_isa_pkg:
  - kind codes;
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3/funct7 constants shared with the main and ALU decoders.
- Sub-module rv_instr_enc: purely combinational (kind, rd, rs1, rs2, imm) → (word, legal).
- The top holds the FSM, wcount and output registers.

## Test plan

- Reset, start, then ADD rd3 rs1 1 rs2 2 → next cycle imem_we = 1, addr 0, wdata 0x002081B3; wcount = 1.
- Back-to-back four requests:
  - SUB 5,6,7 → 0x407302B3 at addr 1.
  - LW x4, 8(x2) → 0x00812203 at addr 2.
  - SW x5, 12(x2) → 0x00512623 at addr 3.
  - BEQ x1,x2,-4 (imm 0x1FFC) → 0xFE208EE3 at addr 4.
  - Check one write per cycle.
- Illegal kind 12 between two ADDs → err = 1, no strobe, addresses remain contiguous; err stays 1 until start.
- DEPTH = 4, hold req_valid for 6 requests → exactly 4 writes at addresses 0–3, req_ready low after the 4th acceptance, state FULL; start → wcount = 0 and LOAD.
- Assert rst_n low in the cycle after an acceptance → imem_we never rises; all outputs 0, state IDLE.
- start during LOAD ignored, and wcount keeps counting; finish then start in the same cycle from IDLE → LOAD.
